result_unpacker: RTL and testbench

RESULT_UNPACKER -- requirements
Module: result_unpacker

---
 rtl/result_unpacker.sv | 155 +++++++++++++++
 tb/tb_result_unpacker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_unpacker.sv
// result_unpacker
//   Buffers packed 90-bit result words in a small FIFO and streams each word
//   out as 18 individual fields. Each field is sign- or zero-extended to
//   8 bits. The XOR of all 18 extended fields of the head word is presented
//   alongside the stream.
//
//   Field k is 4 + (k mod 3) bits wide. Fields are packed MSB-first starting
//   at bit 89. A field is signed when floor(k/3) is odd.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data offered
//   in_ready   : FIFO can take a word this cycle (never while full)
//   in_data    : packed word {y0..y17}, with y0 in [89:86]
//   out_valid  : a field is presented
//   out_ready  : consumer takes the presented field
//   out_idx    : field index, 0..17
//   out_field  : extended field value
//   out_last   : out_idx == 17
//   out_chk    : XOR of all 18 extended fields of the current word
//   word_count : words fully emitted (wraps)
//
// FSM states
//   state | meaning
//   IDLE  | FIFO empty, nothing presented
//   EMIT  | presenting field idx of the FIFO head word
module result_unpacker #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [89:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [7:0]  out_field,
  output logic        out_last,
  output logic [7:0]  out_chk,
  output logic [15:0] word_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state;
  logic [4:0]      idx;
  logic [89:0]     mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            rdy_en;
  logic            full;
  logic            push;
  logic            pop;
  logic [89:0]     head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Extract field k of word w and extend it to 8 bits.
  function automatic logic [7:0] field_ext(input logic [89:0] w, input int k);
    int         grp;
    int         sub;
    int         wd;
    int         lsb;
    logic [5:0] sh;
    logic       sgn;
    logic [7:0] ext;
    grp = k / 3;
    sub = k % 3;
    wd  = 4 + sub;
    // Each group of three fields takes 15 bits; offsets within a group are 0, 4 and 9.
    lsb = 90 - 15 * grp - ((sub == 0) ? 0 : (sub == 1) ? 4 : 9) - wd;
    sh  = 6'(w >> lsb);
    sgn = (grp % 2) == 1;
    case (wd)
      4:       ext = sgn ? {{4{sh[3]}}, sh[3:0]} : {4'b0, sh[3:0]};
      5:       ext = sgn ? {{3{sh[4]}}, sh[4:0]} : {3'b0, sh[4:0]};
      default: ext = sgn ? {{2{sh[5]}}, sh[5:0]} : {2'b0, sh[5:0]};
    endcase
    return ext;
  endfunction

  // rdy_en keeps in_ready low through reset and for the rest of the
  // cycle in which reset is released.
  assign full      = (count == CW'(DEPTH));
  assign in_ready  = rdy_en & ~full;
  assign push      = in_valid & in_ready;
  assign pop       = (state == EMIT) & out_ready & (idx == 5'd17);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head      = mem[rd_ptr];
  assign out_valid = (state == EMIT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      state      <= IDLE;
      word_count <= '0;
    end else begin
      rdy_en <= 1'b1;
      count  <= count_nxt;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case (state)
        IDLE: begin
          idx <= '0;
          if (push) state <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (idx == 5'd17) begin
              idx        <= '0;
              word_count <= word_count + 16'd1;
              if (count_nxt == '0) state <= IDLE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs derive only from registered state and the head word, so they
  // hold steady while the consumer stalls.
  always_comb begin
    out_idx   = '0;
    out_field = '0;
    out_last  = 1'b0;
    out_chk   = '0;
    if (out_valid) begin
      out_idx   = idx;
      out_field = field_ext(head, int'(idx));
      out_last  = (idx == 5'd17);
      for (int k = 0; k < 18; k++) out_chk = out_chk ^ field_ext(head, k);
    end
  end

endmodule

// File: tb/tb_result_unpacker.sv
module tb_result_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [7:0]  out_field;
  logic        out_last;
  logic [7:0]  out_chk;
  logic [15:0] word_count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_f [18];

  localparam logic [89:0] ALL1  = {90{1'b1}};
  localparam logic [89:0] BIT89 = 90'(1) << 89;
  localparam logic [89:0] BIT74 = 90'(1) << 74;

  result_unpacker #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_field(out_field), .out_last(out_last),
    .out_chk(out_chk), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Called and returns at a negedge; the word is accepted on the edge in between.
  task automatic push_word(input logic [89:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 400 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL push_timeout: in_ready=%b required 1 within 400 cycles", in_ready);
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_idx, out_field, out_last, out_chk, word_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b v=%b idx=%0d f=%h l=%b chk=%h wc=%0d required all 0",
               in_ready, out_valid, out_idx, out_field, out_last, out_chk, word_count);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_edge: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_fields(input string name, input logic [89:0] word,
                             input logic [7:0] chk, input logic [15:0] wc);
    out_ready = 1'b1;
    push_word(word);
    for (int k = 0; k < 18; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 5'(k) || out_field !== exp_f[k]
          || out_last !== (k == 17)) begin
        n_fail++;
        $display("FAIL %s_field%0d: v=%b idx=%0d field=%h last=%b required 1/%0d/%h/%b",
                 name, k, out_valid, out_idx, out_field, out_last, k, exp_f[k], k == 17);
      end
      if (k == 17) begin
        n_cmp++;
        if (out_chk !== chk) begin
          n_fail++;
          $display("FAIL %s_chk: out_chk=%h required %h", name, out_chk, chk);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== wc) begin
      n_fail++;
      $display("FAIL %s_done: out_valid=%b word_count=%0d required 0/%0d",
               name, out_valid, word_count, wc);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    push_word(ALL1);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_field !== 8'h0F) begin
        n_fail++;
        $display("FAIL stall_hold%0d: v=%b idx=%0d field=%h required 1/0/0f",
                 c, out_valid, out_idx, out_field);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 18; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_idx !== 5'(k)) begin
        n_fail++;
        $display("FAIL stall_advance: out_idx=%0d required %0d", out_idx, k);
      end
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== 16'd4) begin
      n_fail++;
      $display("FAIL stall_done: out_valid=%b word_count=%0d required 0/4", out_valid, word_count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push_word('0);
    push_word(BIT89);
    in_valid = 1'b1;
    in_data  = ALL1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL full_ready: in_ready=%b out_idx=%0d required 0/0", in_ready, out_idx);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_idx !== 5'(k)) begin
        n_fail++;
        $display("FAIL full_drain%0d: in_ready=%b out_idx=%0d required 0/%0d",
                 k, in_ready, out_idx, k);
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_idx !== 5'd0 || out_field !== 8'h08) begin
      n_fail++;
      $display("FAIL second_word: rdy=%b v=%b idx=%0d field=%h required 1/1/0/08",
               in_ready, out_valid, out_idx, out_field);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_field !== 8'h0F || word_count !== 16'd6) begin
      n_fail++;
      $display("FAIL no_bubble: v=%b idx=%0d field=%h wc=%0d required 1/0/0f/6",
               out_valid, out_idx, out_field, word_count);
    end
    repeat (18) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== 16'd7) begin
      n_fail++;
      $display("FAIL b2b_done: out_valid=%b word_count=%0d required 0/7", out_valid, word_count);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    push_word(ALL1);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (out_idx !== 5'd7) begin
      n_fail++;
      $display("FAIL midrst_setup: out_idx=%0d required 7", out_idx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== 16'd0 || out_idx !== 5'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_now: v=%b wc=%0d idx=%0d rdy=%b required 0/0/0/0",
               out_valid, word_count, out_idx, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_quiet%0d: out_valid=%b required 0", c, out_valid);
      end
    end
    push_word(BIT89);
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_field !== 8'h08) begin
      n_fail++;
      $display("FAIL midrst_new: v=%b idx=%0d field=%h required 1/0/08", out_valid, out_idx, out_field);
    end
    repeat (18) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== 16'd1) begin
      n_fail++;
      $display("FAIL midrst_done: out_valid=%b word_count=%0d required 0/1", out_valid, word_count);
    end
  endtask

  initial begin
    test_reset();

    for (int k = 0; k < 18; k++) begin
      if ((k / 3) % 2 == 1) exp_f[k] = 8'hFF;
      else if (k % 3 == 0)  exp_f[k] = 8'h0F;
      else if (k % 3 == 1)  exp_f[k] = 8'h1F;
      else                  exp_f[k] = 8'h3F;
    end
    test_fields("all_ones", ALL1, 8'hD0, 16'd1);

    for (int k = 0; k < 18; k++) exp_f[k] = 8'h00;
    exp_f[0] = 8'h08;
    test_fields("bit89", BIT89, 8'h08, 16'd2);

    for (int k = 0; k < 18; k++) exp_f[k] = 8'h00;
    exp_f[3] = 8'hF8;
    test_fields("bit74", BIT74, 8'hF8, 16'd3);

    test_stall();
    test_back_to_back();
    test_mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
